multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore/Mealy FSM sequencing the shared-memory multi-cycle MIPS datapath (one memory for instr+data, one ALU).
//  Decodes opcode from the IR and steps FETCH/DECODE/EXECUTE/MEM/WB, stalling on a memory ready handshake.
//  Opcode map: 000000 R, 000001 lw, 000010 sw, 000011 addi, 000100 slti, 000101 j, 000110 jal, 000111 jr, 001000 beq.
//  alu_op to ALU control: 00 funct, 01 add, 10 sub, 11 slt.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready before bus_error (1..255)
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  OPCcode      in   6  IR[31:26], stable from DECODE onward
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if ALU zero (beq)
//  pc_src       out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 register (jr)
//  i_or_d       out  1  0 memory addr=PC, 1 addr=ALUOut
//  mem_read, mem_write, ir_write  out 1 each  memory strobes / IR load
//  reg_dst, r31, reg_write, mem_to_reg, write_pc_4  out 1 each  regfile write control
//  alu_src_a    out  1  0 PC, 1 reg A
//  alu_src_b    out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op       out  2  see PURPOSE
//  retire       out  1  one-cycle pulse in final cycle of each completed instruction
//  illegal_op   out  1  one-cycle pulse, unknown opcode in DECODE
//  bus_error    out  1  one-cycle pulse on memory timeout
//  state        out  4  current state (debug)
// BEHAVIOUR
//  Reset: while rst=1 every output is 0; state<=FETCH, wait counter<=0. First fetch starts the cycle after rst falls.
//  Outputs are decoded from state; signals marked [rdy] assert only in cycles where mem_ready=1. Unlisted outputs 0.
//  FETCH: i_or_d=0 mem_read=1; [rdy] ir_write=1 pc_write=1 a=0 b=01 op=01 pc_src=00 -> DECODE; else stay.
//  DECODE: a=0 b=11 op=01 (branch target into ALUOut). Next: R->EX_R, lw/sw->ADDR, addi->EX_ADDI,
//    slti->EX_SLTI, j->JUMP, jal->JAL, jr->JR, beq->BRANCH, other->FETCH with illegal_op=1 (no retire).
//  ADDR: a=1 b=10 op=01 -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: i_or_d=1 mem_read=1; [rdy] -> WB_MEM. MEM_WR: i_or_d=1 mem_write=1; [rdy] retire=1 -> FETCH.
//  WB_MEM: reg_write=1 mem_to_reg=1 reg_dst=0 retire=1 -> FETCH.
//  EX_R: a=1 b=00 op=00 -> WB_R (reg_dst=1 reg_write=1 retire=1) -> FETCH.
//  EX_ADDI: a=1 b=10 op=01; EX_SLTI: a=1 b=10 op=11; both -> WB_I (reg_dst=0 reg_write=1 retire=1) -> FETCH.
//  BRANCH: a=1 b=00 op=10 pc_write_cond=1 pc_src=01 retire=1 -> FETCH.
//  JUMP: pc_write=1 pc_src=10 retire=1 -> FETCH.
//  JAL: pc_write=1 pc_src=10 reg_write=1 r31=1 write_pc_4=1 retire=1 -> FETCH (PC+4 already in PC).
//  JR: pc_write=1 pc_src=11 retire=1 -> FETCH.
//  Latency with zero wait states: j/jal/jr/beq 3 cycles, R/addi/slti/sw 4, lw 5; +1 per mem_ready=0 cycle.
//  Wait counter (8 bit): cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle there with mem_ready=0.
//    When counter==MEM_TIMEOUT and mem_ready=0: bus_error=1, strobes still asserted that cycle, -> FETCH
//    (FETCH timeout retries fetch, PC unchanged; MEM timeout abandons instr, no reg write, no retire).
//    mem_ready=1 on the timeout cycle wins: normal completion, no bus_error.
//  rst mid-instruction: abandons immediately, no partial write after rst rises; outputs 0 the same cycle.
//  State encoding 4 bit; unused codes -> FETCH next cycle, outputs 0.
// TESTING
//  rst 3 cycles, mem_ready=1, OPCcode=000000 -> all outputs 0 during rst; FETCH,DECODE,EX_R,WB_R; retire at cycle 4.
//  lw, mem_ready low 2 cycles in FETCH and 1 in MEM_RD -> 8 cycles total, mem_to_reg=reg_write=1 in last cycle only.
//  beq then jal -> beq 3 cycles with pc_write_cond=1 pc_src=01 op=10; jal: r31=write_pc_4=reg_write=pc_write=1.
//  sw, mem_ready held 0, MEM_TIMEOUT=3 -> bus_error pulse at 4th MEM_WR cycle, next state FETCH, no retire.
//  OPCcode=111111 -> illegal_op one pulse in DECODE, back to FETCH, no reg_write/pc_write beyond fetch.
//  rst asserted in MEM_WR with mem_write=1 -> mem_write=0 same cycle, state FETCH after rst falls.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multi-cycle MIPS datapath.
// Outputs are decoded from state; memory-phase outputs also depend on mem_ready.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPCcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       r31,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       write_pc_4,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_ADDR    = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WR  = 4'd4,
    S_WB_MEM  = 4'd5,
    S_EX_R    = 4'd6,
    S_WB_R    = 4'd7,
    S_EX_ADDI = 4'd8,
    S_EX_SLTI = 4'd9,
    S_WB_I    = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       timeout;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = in_wait && !mem_ready && (wait_cnt == TIMEOUT);
  assign state   = rst ? 4'd0 : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Any exit from a wait state (including a timeout retry of FETCH) is an entry that clears the counter.
      if (in_wait && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    r31           = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    write_pc_4    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    retire        = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = 2'b01;
            state_d   = S_DECODE;
          end else if (timeout) begin
            bus_error = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = 2'b01;
          case (OPCcode)
            6'b000000: state_d = S_EX_R;
            6'b000001,
            6'b000010: state_d = S_ADDR;
            6'b000011: state_d = S_EX_ADDI;
            6'b000100: state_d = S_EX_SLTI;
            6'b000101: state_d = S_JUMP;
            6'b000110: state_d = S_JAL;
            6'b000111: state_d = S_JR;
            6'b001000: state_d = S_BRANCH;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b01;
          state_d   = (OPCcode == 6'b000001) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            state_d = S_WB_MEM;
          end else if (timeout) begin
            bus_error = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_MEM_WR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (timeout) begin
            bus_error = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          state_d   = S_WB_R;
        end
        S_WB_R: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_EX_ADDI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b01;
          state_d   = S_WB_I;
        end
        S_EX_SLTI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
          state_d   = S_WB_I;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b10;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = 1'b1;
          r31        = 1'b1;
          write_pc_4 = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: hand-written vector table for the corner sequences,
// then random opcodes/handshake checked against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int unsigned T = 3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       r31;
    logic       reg_write;
    logic       mem_to_reg;
    logic       write_pc_4;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal_op;
    logic       bus_error;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] OPCcode = '0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, r31, reg_write, mem_to_reg, write_pc_4, alu_src_a;
  logic       retire, illegal_op, bus_error;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;
  outs_t      got;

  int unsigned checks = 0;
  int unsigned passes = 0;
  vec_t        tv[$];

  multicycle_controller #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .OPCcode(OPCcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .r31(r31), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .write_pc_4(write_pc_4), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .retire(retire), .illegal_op(illegal_op), .bus_error(bus_error),
    .state(state)
  );

  always #5 clk = ~clk;

  assign got = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, r31, reg_write, mem_to_reg, write_pc_4, alu_src_a, alu_src_b,
                alu_op, retire, illegal_op, bus_error};

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input outs_t e,
                     input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e; v.name = nm;
    tv.push_back(v);
  endtask

  // Drive on the falling edge, compare 1 time unit later; the next rising edge then acts on it.
  task automatic drive_and_check(input logic r, input logic [5:0] op, input logic rdy,
                                 input outs_t e, input string nm);
    @(negedge clk);
    rst = r; OPCcode = op; mem_ready = rdy;
    #1;
    checks++;
    if (got === e && (!r || state === 4'd0))
      passes++;
    else
      $display("FAIL %s: got outs=%h state=%h, want outs=%h%s", nm, got, state, e,
               r ? " state=0" : "");
  endtask

  // Reference model: expected controls from instruction class and step number within it.
  function automatic outs_t model_out(input int ph, input int cls, input logic [5:0] op,
                                      input logic rdy, input logic tmo);
    outs_t e = '0;
    case (ph)
      0: begin
        e.mem_read = 1;
        if (rdy) begin e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; e.alu_op = 2'b01; end
        e.bus_error = tmo;
      end
      1: begin e.alu_src_b = 2'b11; e.alu_op = 2'b01; e.illegal_op = (op > 6'd8); end
      2: case (cls)
        0: e.alu_src_a = 1;
        1, 2, 3: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b01; end
        4: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
        5: begin e.pc_write = 1; e.pc_src = 2'b10; e.retire = 1; end
        6: begin e.pc_write = 1; e.pc_src = 2'b10; e.retire = 1;
                 e.reg_write = 1; e.r31 = 1; e.write_pc_4 = 1; end
        7: begin e.pc_write = 1; e.pc_src = 2'b11; e.retire = 1; end
        default: begin e.alu_src_a = 1; e.alu_op = 2'b10; e.pc_write_cond = 1;
                       e.pc_src = 2'b01; e.retire = 1; end
      endcase
      3: case (cls)
        0: begin e.reg_dst = 1; e.reg_write = 1; e.retire = 1; end
        1: begin e.i_or_d = 1; e.mem_read = 1; e.bus_error = tmo; end
        2: begin e.i_or_d = 1; e.mem_write = 1; e.retire = rdy; e.bus_error = tmo; end
        default: begin e.reg_write = 1; e.retire = 1; end
      endcase
      default: begin e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
    endcase
    return e;
  endfunction

  initial begin
    outs_t z, f_wait, f_rdy, dec, e;
    int ph, cls, cnt, last;
    logic stall, r, rdy, tmo, waiting;
    logic [5:0] op;

    z = '0;
    f_wait = '0; f_wait.mem_read = 1;
    f_rdy = f_wait; f_rdy.ir_write = 1; f_rdy.pc_write = 1; f_rdy.alu_src_b = 2'b01; f_rdy.alu_op = 2'b01;
    dec = '0; dec.alu_src_b = 2'b11; dec.alu_op = 2'b01;

    // reset then R-type, retire in cycle 4
    for (int i = 0; i < 3; i++) add(1, 6'd0, 1, z, "rst");
    add(0, 6'd0, 1, f_rdy, "r_fetch");
    add(0, 6'd0, 1, dec, "r_decode");
    e = '0; e.alu_src_a = 1; add(0, 6'd0, 1, e, "r_ex");
    e = '0; e.reg_dst = 1; e.reg_write = 1; e.retire = 1; add(0, 6'd0, 1, e, "r_wb");
    // lw with 2 fetch waits and 1 memory wait: 8 cycles
    add(0, 6'd1, 0, f_wait, "lw_fw0");
    add(0, 6'd1, 0, f_wait, "lw_fw1");
    add(0, 6'd1, 1, f_rdy, "lw_fetch");
    add(0, 6'd1, 1, dec, "lw_decode");
    e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b01; add(0, 6'd1, 1, e, "lw_addr");
    e = '0; e.i_or_d = 1; e.mem_read = 1;
    add(0, 6'd1, 0, e, "lw_mw");
    add(0, 6'd1, 1, e, "lw_mem");
    e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; add(0, 6'd1, 1, e, "lw_wb");
    // beq then jal
    add(0, 6'd8, 1, f_rdy, "beq_fetch");
    add(0, 6'd8, 1, dec, "beq_decode");
    e = '0; e.alu_src_a = 1; e.alu_op = 2'b10; e.pc_write_cond = 1; e.pc_src = 2'b01; e.retire = 1;
    add(0, 6'd8, 1, e, "beq_br");
    add(0, 6'd6, 1, f_rdy, "jal_fetch");
    add(0, 6'd6, 1, dec, "jal_decode");
    e = '0; e.pc_write = 1; e.pc_src = 2'b10; e.reg_write = 1; e.r31 = 1; e.write_pc_4 = 1; e.retire = 1;
    add(0, 6'd6, 1, e, "jal_jump");
    // sw with memory timeout: bus_error in the 4th MEM_WR cycle, no retire
    add(0, 6'd2, 1, f_rdy, "sw_fetch");
    add(0, 6'd2, 1, dec, "sw_decode");
    e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b01; add(0, 6'd2, 0, e, "sw_addr");
    e = '0; e.i_or_d = 1; e.mem_write = 1;
    for (int i = 0; i < 3; i++) add(0, 6'd2, 0, e, "sw_wait");
    e.bus_error = 1; add(0, 6'd2, 0, e, "sw_timeout");
    // illegal opcode
    add(0, 6'd63, 1, f_rdy, "ill_fetch");
    e = dec; e.illegal_op = 1; add(0, 6'd63, 1, e, "ill_decode");
    add(0, 6'd63, 0, f_wait, "ill_back_fetch");
    // reset while writing memory
    add(0, 6'd2, 1, f_rdy, "sw2_fetch");
    add(0, 6'd2, 1, dec, "sw2_decode");
    e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b01; add(0, 6'd2, 0, e, "sw2_addr");
    e = '0; e.i_or_d = 1; e.mem_write = 1; add(0, 6'd2, 0, e, "sw2_mw");
    add(1, 6'd2, 0, z, "sw2_rst");
    // fetch timeout retries fetch, then addi
    for (int i = 0; i < 3; i++) add(0, 6'd3, 0, f_wait, "ft_wait");
    e = f_wait; e.bus_error = 1; add(0, 6'd3, 0, e, "ft_timeout");
    add(0, 6'd3, 0, f_wait, "ft_retry");
    add(0, 6'd3, 1, f_rdy, "addi_fetch");
    add(0, 6'd3, 1, dec, "addi_decode");
    e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b01; add(0, 6'd3, 1, e, "addi_ex");
    e = '0; e.reg_write = 1; e.retire = 1; add(0, 6'd3, 1, e, "addi_wb");

    foreach (tv[i]) drive_and_check(tv[i].rst, tv[i].op, tv[i].rdy, tv[i].exp, tv[i].name);

    // random phase, starting from a fresh reset
    drive_and_check(1, 6'd0, 1, z, "rnd_rst");
    ph = 0; cls = 0; cnt = 0; stall = 0; op = '0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      if (ph == 0) begin
        op = ($urandom_range(0, 9) == 9) ? 6'($urandom_range(9, 63)) : 6'($urandom_range(0, 8));
      end
      waiting = (ph == 0) || (ph == 3 && (cls == 1 || cls == 2));
      if (waiting && cnt == 0) stall = ($urandom_range(0, 9) == 0);
      rdy = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      tmo = waiting && !rdy && (cnt == int'(T));
      drive_and_check(r, op, rdy, r ? z : model_out(ph, cls, op, rdy, tmo), "rnd");
      if (r) begin
        ph = 0; cnt = 0;
      end else if (waiting) begin
        if (rdy) begin
          cnt = 0;
          if (ph == 0) ph = 1;
          else ph = (cls == 1) ? 4 : 0;
        end else if (tmo) begin
          cnt = 0; ph = 0;
        end else begin
          cnt++;
        end
      end else if (ph == 1) begin
        if (op > 6'd8) ph = 0;
        else begin cls = int'(op); ph = 2; end
      end else begin
        last = (cls >= 5) ? 2 : (cls == 1) ? 4 : 3;
        ph = (ph == last) ? 0 : ph + 1;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
